// File: rtl/mips_fwd_pkg.sv
// -----------------------------------------------------------------------------
// mips_fwd_pkg
//
// Shared types and constants for the EX-stage forwarding / hazard logic of the
// 5-stage MIPS core.
//
// Contents:
//   FWD_RF / FWD_EXMEM / FWD_MEMWB / FWD_RET : 2-bit operand-mux select codes.
//   REG_ZERO                                 : index of the hard-wired $0.
//   stage_entry_t                            : {valid, dest, reg_write, mem_read}
//                                              shadow of one pipeline stage.
//   entry_writes()                           : "this stage will write src".
//
// The register-index field is sized to REG_W_MAX.  Narrower indices are
// zero-extended at the top level, which keeps equality compares exact.
// -----------------------------------------------------------------------------
package mips_fwd_pkg;

  localparam int REG_W_MAX = 8;

  typedef logic [REG_W_MAX-1:0] reg_idx_t;

  localparam logic [1:0] FWD_RF    = 2'b00;  // operand from the register file
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // operand from the EX/MEM latch
  localparam logic [1:0] FWD_MEMWB = 2'b10;  // operand from the MEM/WB latch
  localparam logic [1:0] FWD_RET   = 2'b11;  // operand from the retired write

  localparam reg_idx_t REG_ZERO = '0;

  typedef struct packed {
    logic     valid;
    reg_idx_t dest;
    logic     reg_write;
    logic     mem_read;
  } stage_entry_t;

  // A stage is in-flight-writing src when it holds a real instruction that
  // writes a non-zero register equal to src.  $0 therefore never matches.
  function automatic logic entry_writes(input stage_entry_t e, input reg_idx_t src);
    return e.valid && e.reg_write && (e.dest != REG_ZERO) && (e.dest == src);
  endfunction

endpackage

// File: rtl/fwd_compare.sv
// -----------------------------------------------------------------------------
// fwd_compare
//
// Priority comparator for one ALU operand.  Given the source register read in
// ID and the three shadow entries (EX, MEM, WB), returns the select the
// operand mux must use during the instruction's EX cycle.  The nearest
// producer wins: EX beats MEM, which beats WB.
//
// Ports:
//   i_src  : source register index (zero-extended)
//   i_use  : the instruction actually reads this source
//   i_ex   : shadow of the instruction currently in EX
//   i_mem  : shadow of the instruction currently in MEM
//   i_wb   : shadow of the instruction currently in WB
//   o_sel  : 2-bit operand select (mips_fwd_pkg codes)
//
// Build option FWD_RET_BYPASS_EN:
//   defined   -> a WB match yields FWD_RET (register file is read-before-write)
//   undefined -> a WB match yields FWD_RF  (register file is write-first, so
//                the value is already visible through the normal read port)
// -----------------------------------------------------------------------------
module fwd_compare
  import mips_fwd_pkg::*;
(
  input  reg_idx_t     i_src,
  input  logic         i_use,
  input  stage_entry_t i_ex,
  input  stage_entry_t i_mem,
  input  stage_entry_t i_wb,
  output logic [1:0]   o_sel
);

  logic w_hit_ex;
  logic w_hit_mem;
  logic w_hit_wb;

  assign w_hit_ex  = i_use && entry_writes(i_ex,  i_src);
  assign w_hit_mem = i_use && entry_writes(i_mem, i_src);
  assign w_hit_wb  = i_use && entry_writes(i_wb,  i_src);

  always_comb begin
    o_sel = FWD_RF;
    if (w_hit_ex) begin
      o_sel = FWD_EXMEM;
    end else if (w_hit_mem) begin
      o_sel = FWD_MEMWB;
    end else if (w_hit_wb) begin
`ifdef FWD_RET_BYPASS_EN
      o_sel = FWD_RET;
`else
      o_sel = FWD_RF;
`endif
    end
  end

  // Load flags of the older stages do not influence forwarding; only the
  // EX entry's load flag matters, and that is consumed by the stall logic.
  logic w_unused_fields;
  assign w_unused_fields = &{1'b0, i_mem.mem_read, i_wb.mem_read, w_hit_wb};

endmodule

// File: rtl/forward_hazard_unit.sv
// -----------------------------------------------------------------------------
// forward_hazard_unit
//
// Hazard tracker at the ID/EX boundary of the 5-stage MIPS core.  Shadows the
// destination/write-type of the instructions in EX, MEM and WB and, one cycle
// ahead, produces registered operand selects for the two EX-stage 4:1 muxes.
// Raises a combinational load-use stall and inserts a bubble into EX when a
// load result cannot be forwarded in time.
//
// Parameters:
//   REG_W         : register-index width (default 5, must not exceed REG_W_MAX)
//
// Ports:
//   Clk           : clock, rising edge
//   Reset         : synchronous, active-high
//   id_valid      : ID holds a real instruction
//   id_rs, id_rt  : source register indices
//   id_use_rs/rt  : the instruction reads that source
//   id_dest       : destination register (rd or rt, already resolved)
//   id_reg_write  : the instruction writes the register file
//   id_mem_read   : the instruction is a load
//   flush         : taken branch, squash the ID instruction
//   stall         : combinational, freezes PC and IF/ID
//   fwd_a_sel     : registered rs-operand select, valid for the EX cycle
//   fwd_b_sel     : registered rt-operand select, valid for the EX cycle
//   ex_bubble     : registered, current EX slot is a bubble
//
// Build option FWD_RET_BYPASS_EN (see fwd_compare): enables select 11 for
// matches against the WB entry.
// -----------------------------------------------------------------------------
module forward_hazard_unit
  import mips_fwd_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             ex_bubble
);

  // Shadow entries; they shift EX -> MEM -> WB every clock and never hold.
  stage_entry_t r_ex;
  stage_entry_t r_mem;
  stage_entry_t r_wb;

  logic [1:0] r_fwd_a_sel;
  logic [1:0] r_fwd_b_sel;
  logic       r_ex_bubble;

  reg_idx_t     w_rs;
  reg_idx_t     w_rt;
  reg_idx_t     w_dest;
  logic [1:0]   w_sel_a;
  logic [1:0]   w_sel_b;
  logic         w_load_use;
  logic         w_issue;
  stage_entry_t w_ex_next;

  assign w_rs   = reg_idx_t'(id_rs);
  assign w_rt   = reg_idx_t'(id_rt);
  assign w_dest = reg_idx_t'(id_dest);

  // ---------------------------------------------------------------------------
  // Per-operand select decision, made in ID.
  // ---------------------------------------------------------------------------
  fwd_compare u_cmp_rs (
    .i_src (w_rs),
    .i_use (id_use_rs),
    .i_ex  (r_ex),
    .i_mem (r_mem),
    .i_wb  (r_wb),
    .o_sel (w_sel_a)
  );

  fwd_compare u_cmp_rt (
    .i_src (w_rt),
    .i_use (id_use_rt),
    .i_ex  (r_ex),
    .i_mem (r_mem),
    .i_wb  (r_wb),
    .o_sel (w_sel_b)
  );

  // ---------------------------------------------------------------------------
  // Load-use detection.  Only the EX entry can cause it: a load one stage
  // further along is already in MEM/WB by the consumer's EX cycle.  Depends on
  // ID inputs and r_ex only, so there is no loop through stall.
  // ---------------------------------------------------------------------------
  assign w_load_use = r_ex.mem_read &&
                      ((id_use_rs && entry_writes(r_ex, w_rs)) ||
                       (id_use_rt && entry_writes(r_ex, w_rt)));

  // Flush wins over stall: a squashed instruction has no dependency to wait on.
  assign stall   = id_valid && !flush && w_load_use;
  assign w_issue = id_valid && !flush && !w_load_use;

  always_comb begin
    w_ex_next = '0;
    if (w_issue) begin
      w_ex_next.valid     = 1'b1;
      w_ex_next.dest      = w_dest;
      w_ex_next.reg_write = id_reg_write;
      w_ex_next.mem_read  = id_mem_read;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry shift register and registered mux selects.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_fwd_a_sel <= FWD_RF;
      r_fwd_b_sel <= FWD_RF;
      r_ex_bubble <= 1'b1;
    end else begin
      r_ex        <= w_ex_next;
      r_mem       <= r_ex;
      r_wb        <= r_mem;
      // A bubble in EX must not steer the muxes towards stale producers.
      r_fwd_a_sel <= w_issue ? w_sel_a : FWD_RF;
      r_fwd_b_sel <= w_issue ? w_sel_b : FWD_RF;
      r_ex_bubble <= !w_issue;
    end
  end

  assign fwd_a_sel = r_fwd_a_sel;
  assign fwd_b_sel = r_fwd_b_sel;
  assign ex_bubble = r_ex_bubble;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_forward_hazard_unit
//
// Randomised bench for forward_hazard_unit.  A reference model keeps the last
// three EX-slot occupants as a list of instructions and derives the expected
// stall and operand selects from the forwarding rules.  Expectations go into
// queues; a monitor pops and compares them against the DUT each cycle.
// -----------------------------------------------------------------------------
module tb_forward_hazard_unit;

  localparam int REG_W   = 5;
  localparam int N_CYC   = 1500;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [REG_W-1:0] id_dest;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             flush;
  logic             stall;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             ex_bubble;

  always #5 Clk = ~Clk;

  forward_hazard_unit #(.REG_W(REG_W)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_dest      (id_dest),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .stall        (stall),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .ex_bubble    (ex_bubble)
  );

  // Instruction occupying a pipeline slot in the model (v=0 means bubble).
  typedef struct {
    bit          v;
    int unsigned dest;
    bit          rw;
    bit          mr;
  } slot_t;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic       bub;
  } exp_regs_t;

  exp_regs_t reg_q[$];
  bit        stall_q[$];
  slot_t     pipe[3];   // [0]=EX, [1]=MEM, [2]=WB
  int        checks = 0;
  int        errors = 0;
  int        txn    = 0;

  function automatic bit produces(slot_t s, int unsigned r);
    return s.v && s.rw && (s.dest != 0) && (s.dest == r);
  endfunction

  // Distance to the nearest older producer of r decides the mux source.
  function automatic logic [1:0] model_sel(bit used, int unsigned r);
    if (!used) return 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (produces(pipe[k], r)) begin
        if (k == 2) begin
`ifdef FWD_RET_BYPASS_EN
          return 2'd3;
`else
          return 2'd0;
`endif
        end
        return 2'(k + 1);
      end
    end
    return 2'd0;
  endfunction

  task automatic check(string name, int actual, int required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s txn=%0d actual=%0d required=%0d", name, txn, actual, required);
    end
  endtask

  // Monitor: registered outputs checked after each rising edge, stall checked
  // after inputs settle in the low phase.
  initial begin
    exp_regs_t e;
    bit        s;
    forever begin
      @(posedge Clk); #2;
      if (reg_q.size() > 0) begin
        e = reg_q.pop_front();
        txn++;
        check("fwd_a_sel", int'(fwd_a_sel), int'(e.a));
        check("fwd_b_sel", int'(fwd_b_sel), int'(e.b));
        check("ex_bubble", int'(ex_bubble), int'(e.bub));
        $display("txn %0d: a_sel=%0d b_sel=%0d ex_bubble=%0d (exp %0d %0d %0d)",
                 txn, fwd_a_sel, fwd_b_sel, ex_bubble, e.a, e.b, e.bub);
      end
      @(negedge Clk); #2;
      if (stall_q.size() > 0) begin
        s = stall_q.pop_front();
        check("stall", int'(stall), int'(s));
      end
    end
  end

  // Stimulus and reference model.
  initial begin
    bit        held;
    bit        exp_stall;
    bit        issue;
    exp_regs_t e;
    slot_t     nw;
    slot_t     bubble;

    bubble = '{v:1'b0, dest:0, rw:1'b0, mr:1'b0};
    for (int k = 0; k < 3; k++) pipe[k] = bubble;
    held         = 1'b0;
    Reset        = 1'b1;
    id_valid     = 1'b0;
    id_rs        = '0;
    id_rt        = '0;
    id_use_rs    = 1'b0;
    id_use_rt    = 1'b0;
    id_dest      = '0;
    id_reg_write = 1'b0;
    id_mem_read  = 1'b0;
    flush        = 1'b0;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge Clk);
      // A stalled instruction stays in ID (IF/ID frozen).
      if (!held) begin
        id_valid     = ($urandom_range(0, 9) != 0);
        id_rs        = REG_W'($urandom_range(0, 7));
        id_rt        = REG_W'($urandom_range(0, 7));
        id_use_rs    = ($urandom_range(0, 4) != 0);
        id_use_rt    = ($urandom_range(0, 4) != 0);
        id_dest      = REG_W'($urandom_range(0, 7));
        id_reg_write = ($urandom_range(0, 4) != 0);
        id_mem_read  = ($urandom_range(0, 2) == 0);
      end
      Reset = (cyc < 2) || ($urandom_range(0, 149) == 0);
      flush = ($urandom_range(0, 9) == 0);
      #1;

      exp_stall = id_valid && !flush && pipe[0].mr &&
                  ((id_use_rs && produces(pipe[0], int'(id_rs))) ||
                   (id_use_rt && produces(pipe[0], int'(id_rt))));
      // Occasionally reset right in a stall cycle.
      if (exp_stall && $urandom_range(0, 5) == 0) Reset = 1'b1;
      stall_q.push_back(exp_stall);

      issue = id_valid && !flush && !exp_stall;
      if (Reset) begin
        e = '{a:2'd0, b:2'd0, bub:1'b1};
      end else if (issue) begin
        e = '{a:model_sel(id_use_rs, int'(id_rs)),
              b:model_sel(id_use_rt, int'(id_rt)), bub:1'b0};
      end else begin
        e = '{a:2'd0, b:2'd0, bub:1'b1};
      end
      reg_q.push_back(e);

      if (Reset) begin
        for (int k = 0; k < 3; k++) pipe[k] = bubble;
      end else begin
        nw = issue ? '{v:1'b1, dest:int'(id_dest), rw:id_reg_write, mr:id_mem_read} : bubble;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = nw;
      end
      held = exp_stall;
    end

    @(posedge Clk); #4;
    check("queues_drained", reg_q.size() + stall_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
